// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// a per-digit leading-zero blank mask for the 7-segment scan driver.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk_100MHz_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     lz_mask_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned SCR_W = BCD_W + BIN_W;

    // Reset mask: every digit above the units digit is blanked.
    localparam logic [DIGITS-1:0] LZ_RESET = ~DIGITS'(1);

    // True when DIGITS decimal digits can hold every BIN_W-bit value.
    function automatic bit digits_sufficient();
        longint unsigned pow10;
        longint unsigned lim;
        pow10 = 64'd1;
        lim   = 64'd1 << BIN_W;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (pow10 >= lim) return 1'b1;
            pow10 = pow10 * 64'd10;
        end
        return pow10 >= lim;
    endfunction

    if (!digits_sufficient()) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [BCD_W-1:0]   bcd_s;
    logic [BIN_W-1:0]   bin_s;
    logic [CNT_W-1:0]   cnt;

    logic               load_c;
    logic               shift_c;
    logic               done_c;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [SCR_W-1:0]   scr_shift_c;
    logic [DIGITS-1:0]  lz_mask_c;

    // State register
    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM control strobes
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        done_c  = 1'b0;
        case (state)
            S_IDLE:  load_c  = start_i;
            S_SHIFT: shift_c = 1'b1;
            S_DONE:  done_c  = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    always_comb begin
        bcd_adj_c = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_s[4*d +: 4] >= 4'd5) begin
                bcd_adj_c[4*d +: 4] = bcd_s[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj_c[4*d +: 4] = bcd_s[4*d +: 4];
            end
        end
    end

    assign scr_shift_c = {bcd_adj_c, bin_s} << 1;

    // Leading-zero mask: scan from the most significant digit down; units never blanked
    always_comb begin
        logic upper_zero;
        int unsigned k;
        upper_zero = 1'b1;
        lz_mask_c  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            k          = DIGITS - 1 - i;
            upper_zero = upper_zero & (bcd_s[4*k +: 4] == 4'd0);
            lz_mask_c[k] = (k != 0) && upper_zero;
        end
    end

    // Scratch register and bit counter
    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            bcd_s <= '0;
            bin_s <= '0;
            cnt   <= '0;
        end else if (load_c) begin
            bcd_s <= '0;
            bin_s <= bin_i;
            cnt   <= CNT_W'(BIN_W);
        end else if (shift_c) begin
            bcd_s <= scr_shift_c[SCR_W-1 -: BCD_W];
            bin_s <= scr_shift_c[BIN_W-1:0];
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Registered outputs; result fields only move on the DONE edge
    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            bcd_o     <= '0;
            lz_mask_o <= LZ_RESET;
        end else begin
            busy_o  <= (state_nxt != S_IDLE);
            valid_o <= done_c;
            if (done_c) begin
                bcd_o     <= bcd_s;
                lz_mask_o <= lz_mask_c;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected digits/masks
// derived from a decimal model, compared when valid_o pulses.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned LAT    = 18;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [BIN_W-1:0]    bin_i;
    logic                busy_o;
    logic                valid_o;
    logic [4*DIGITS-1:0] bcd_o;
    logic [DIGITS-1:0]   lz_mask_o;

    typedef struct packed {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk_100MHz_i (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .bin_i        (bin_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .bcd_o        (bcd_o),
        .lz_mask_o    (lz_mask_o)
    );

    // Decimal reference: repeated divide by ten, then mask from the top down
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned r;
        bit          upper_zero;
        r = v;
        e = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            e.bcd[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
        upper_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (e.bcd[4*k +: 4] == 4'd0);
            e.mask[k]  = (k != 0) && upper_zero;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        bin_i   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || bcd_o !== 20'h00000 || lz_mask_o !== 5'b11110) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b bcd=%h mask=%b, want 0 0 00000 11110",
                     busy_o, valid_o, bcd_o, lz_mask_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max();
        exp_t e;
        bit   early;
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 16'hFFFF;
        sb.push_back(model(32'hFFFF));
        early = 1'b0;
        for (int i = 1; i < int'(LAT); i++) begin
            @(negedge clk);
            start_i = 1'b0;
            bin_i   = 16'($urandom);
            if (valid_o !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL max_latency_early: valid_o seen before edge N+17, want none");
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL max_valid: valid_o=%b after edge N+17, want 1", valid_o);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL max_scoreboard: valid with empty scoreboard");
        end else begin
            e = sb.pop_front();
            checks++;
            if (bcd_o !== e.bcd || lz_mask_o !== e.mask) begin
                errors++;
                $display("FAIL max_result: bcd=%h mask=%b, want %h %b", bcd_o, lz_mask_o, e.bcd, e.mask);
            end
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || bcd_o !== 20'h65535) begin
            errors++;
            $display("FAIL max_hold: valid=%b bcd=%h, want 0 65535", valid_o, bcd_o);
        end
    endtask

    task automatic test_values();
        int unsigned vals[8] = '{1234, 0, 9, 10, 99, 100, 9999, 10000};
        exp_t        e;
        int          lat;
        foreach (vals[i]) begin
            @(negedge clk);
            start_i = 1'b1;
            bin_i   = 16'(vals[i]);
            sb.push_back(model(vals[i]));
            @(negedge clk);
            start_i = 1'b0;
            bin_i   = 16'($urandom);
            lat     = 1;
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL value_busy %0d: busy=%b, want 1", vals[i], busy_o);
            end
            while (valid_o !== 1'b1 && lat < 40) begin
                @(negedge clk);
                bin_i = 16'($urandom);
                lat++;
            end
            checks++;
            if (valid_o !== 1'b1) begin
                errors++;
                $display("FAIL value_timeout %0d: no valid_o within 40 cycles", vals[i]);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL value_scoreboard %0d: valid with empty scoreboard", vals[i]);
            end else begin
                e = sb.pop_front();
                if (lat != int'(LAT) || bcd_o !== e.bcd || lz_mask_o !== e.mask) begin
                    errors++;
                    $display("FAIL value_%0d: lat=%0d bcd=%h mask=%b, want lat=%0d %h %b",
                             vals[i], lat, bcd_o, lz_mask_o, LAT, e.bcd, e.mask);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   first;
        int   second;
        int   nvalid;
        bit   busy_drop;
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 16'd7;
        sb.push_back(model(7));
        first     = -1;
        second    = -1;
        nvalid    = 0;
        busy_drop = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                nvalid++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_scoreboard: valid at cycle %0d with empty scoreboard", i);
                end else begin
                    e = sb.pop_front();
                    if (bcd_o !== e.bcd || lz_mask_o !== e.mask) begin
                        errors++;
                        $display("FAIL b2b_result: bcd=%h mask=%b, want %h %b", bcd_o, lz_mask_o, e.bcd, e.mask);
                    end
                end
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (first > 0 && second < 0 && i > first && busy_o !== 1'b1) busy_drop = 1'b1;
            if (i == 18) begin
                bin_i = 16'd42;
                sb.push_back(model(42));
            end else if (i >= 19) begin
                start_i = 1'b0;
                bin_i   = 16'($urandom);
            end else begin
                bin_i = 16'($urandom);
            end
        end
        checks++;
        if (first != 18 || second - first != 18) begin
            errors++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, want 18 36", first, second);
        end
        checks++;
        if (busy_drop) begin
            errors++;
            $display("FAIL b2b_busy: busy_o dropped between results, want held");
        end
        checks++;
        if (nvalid != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d results, want 2", nvalid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 16'd500;
        repeat (6) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || bcd_o !== 20'h00000 || lz_mask_o !== 5'b11110) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b bcd=%h mask=%b, want 0 0 00000 11110",
                     busy_o, valid_o, bcd_o, lz_mask_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_abort: activity after reset, want none");
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        bin_i   = '0;
        test_reset();
        test_max();
        test_values();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
